// File: rtl/l2_request_interface_if.sv
// l2_request_interface_if: L1 miss-queue dequeue, L2 request/response and wake/fill bundle.
// The master modport is the l2_request_interface side, and the slave modport is the environment side.
interface l2_request_interface_if #(
  parameter int IDX_WIDTH = 2,
  parameter int LINE_BITS = 512
);
  logic                 icache_dequeue_ready;
  logic [31:0]          icache_dequeue_addr;
  logic [IDX_WIDTH-1:0] icache_dequeue_idx;
  logic                 icache_dequeue_ack;
  logic                 dcache_dequeue_ready;
  logic [31:0]          dcache_dequeue_addr;
  logic [IDX_WIDTH-1:0] dcache_dequeue_idx;
  logic                 dcache_dequeue_synchronized;
  logic                 dcache_dequeue_ack;
  logic                 l2_request_valid;
  logic                 l2_request_ready;
  logic [31:0]          l2_request_addr;
  logic                 l2_request_unit;
  logic [IDX_WIDTH-1:0] l2_request_idx;
  logic                 l2_request_synchronized;
  logic                 l2_response_valid;
  logic                 l2_response_unit;
  logic [IDX_WIDTH-1:0] l2_response_idx;
  logic                 l2_response_status;
  logic [LINE_BITS-1:0] l2_response_data;
  logic                 icache_response_valid;
  logic                 dcache_response_valid;
  logic [IDX_WIDTH-1:0] response_idx;
  logic                 response_status;
  logic [LINE_BITS-1:0] response_data;
  modport master (
    input  icache_dequeue_ready, icache_dequeue_addr, icache_dequeue_idx,
    output icache_dequeue_ack,
    input  dcache_dequeue_ready, dcache_dequeue_addr, dcache_dequeue_idx, dcache_dequeue_synchronized,
    output dcache_dequeue_ack,
    output l2_request_valid, l2_request_addr, l2_request_unit, l2_request_idx, l2_request_synchronized,
    input  l2_request_ready,
    input  l2_response_valid, l2_response_unit, l2_response_idx, l2_response_status, l2_response_data,
    output icache_response_valid, dcache_response_valid, response_idx, response_status, response_data
  );
  modport slave (
    output icache_dequeue_ready, icache_dequeue_addr, icache_dequeue_idx,
    input  icache_dequeue_ack,
    output dcache_dequeue_ready, dcache_dequeue_addr, dcache_dequeue_idx, dcache_dequeue_synchronized,
    input  dcache_dequeue_ack,
    input  l2_request_valid, l2_request_addr, l2_request_unit, l2_request_idx, l2_request_synchronized,
    output l2_request_ready,
    output l2_response_valid, l2_response_unit, l2_response_idx, l2_response_status, l2_response_data,
    input  icache_response_valid, dcache_response_valid, response_idx, response_status, response_data
  );
endinterface

// File: rtl/l2_request_interface.sv
// l2_request_interface: round-robin I/D miss arbitration into a single registered L2 request slot with credit limit.
// Optional L2_REQUEST_STATS_EN adds stat_requests_issued / stat_credit_stall_cycles counters.
module l2_request_interface #(
  parameter int IDX_WIDTH       = 2,
  parameter int LINE_BITS       = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic clk,
  input logic reset,
  l2_request_interface_if.master bus
`ifdef L2_REQUEST_STATS_EN
  ,
  output logic [31:0] stat_requests_issued,
  output logic [31:0] stat_credit_stall_cycles
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0] MAX_W = (CW + 1)'(MAX_OUTSTANDING);
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic                 rr_dcache_q, rr_dcache_d;
  logic                 req_valid_q, req_valid_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic                 req_unit_q, req_unit_d;
  logic [IDX_WIDTH-1:0] req_idx_q, req_idx_d;
  logic                 req_sync_q, req_sync_d;
  logic                 icache_rsp_q, icache_rsp_d;
  logic                 dcache_rsp_q, dcache_rsp_d;
  logic [IDX_WIDTH-1:0] rsp_idx_q, rsp_idx_d;
  logic                 rsp_status_q, rsp_status_d;
  logic [LINE_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                 handshake, credit_ok, can_accept, grant_i, grant_d, grant, clear, dec;
  always_comb begin
    handshake     = req_valid_q && bus.l2_request_ready;
    // the request sitting in the slot already holds a credit
    credit_ok     = ({1'b0, outstanding_q} + {{CW{1'b0}}, req_valid_q}) < MAX_W;
    can_accept    = (!req_valid_q || bus.l2_request_ready) && credit_ok;
    grant_i       = can_accept && bus.icache_dequeue_ready && (!bus.dcache_dequeue_ready || !rr_dcache_q);
    grant_d       = can_accept && bus.dcache_dequeue_ready && (!bus.icache_dequeue_ready || rr_dcache_q);
    grant         = grant_i || grant_d;
    clear         = handshake && !grant;
    rr_dcache_d   = (can_accept && bus.icache_dequeue_ready && bus.dcache_dequeue_ready) ? !rr_dcache_q : rr_dcache_q;
    req_valid_d   = grant || (req_valid_q && !handshake);
    req_addr_d    = grant_i ? bus.icache_dequeue_addr : grant_d ? bus.dcache_dequeue_addr : clear ? '0 : req_addr_q;
    req_idx_d     = grant_i ? bus.icache_dequeue_idx : grant_d ? bus.dcache_dequeue_idx : clear ? '0 : req_idx_q;
    req_unit_d    = grant ? grant_d : clear ? 1'b0 : req_unit_q;
    req_sync_d    = grant ? (grant_d && bus.dcache_dequeue_synchronized) : clear ? 1'b0 : req_sync_q;
    // a stray response at zero must not wrap the counter
    dec           = bus.l2_response_valid && (outstanding_q != '0);
    outstanding_d = outstanding_q + CW'(handshake) - CW'(dec);
    icache_rsp_d  = bus.l2_response_valid && !bus.l2_response_unit;
    dcache_rsp_d  = bus.l2_response_valid && bus.l2_response_unit;
    rsp_idx_d     = bus.l2_response_valid ? bus.l2_response_idx : rsp_idx_q;
    rsp_status_d  = bus.l2_response_valid ? bus.l2_response_status : rsp_status_q;
    rsp_data_d    = bus.l2_response_valid ? bus.l2_response_data : rsp_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      rr_dcache_q   <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_unit_q    <= 1'b0;
      req_idx_q     <= '0;
      req_sync_q    <= 1'b0;
      icache_rsp_q  <= 1'b0;
      dcache_rsp_q  <= 1'b0;
      rsp_idx_q     <= '0;
      rsp_status_q  <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      rr_dcache_q   <= rr_dcache_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_unit_q    <= req_unit_d;
      req_idx_q     <= req_idx_d;
      req_sync_q    <= req_sync_d;
      icache_rsp_q  <= icache_rsp_d;
      dcache_rsp_q  <= dcache_rsp_d;
      rsp_idx_q     <= rsp_idx_d;
      rsp_status_q  <= rsp_status_d;
      rsp_data_q    <= rsp_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (!(bus.l2_response_valid && outstanding_q == '0));
  end
  assign bus.icache_dequeue_ack      = grant_i;
  assign bus.dcache_dequeue_ack      = grant_d;
  assign bus.l2_request_valid        = req_valid_q;
  assign bus.l2_request_addr         = req_addr_q;
  assign bus.l2_request_unit         = req_unit_q;
  assign bus.l2_request_idx          = req_idx_q;
  assign bus.l2_request_synchronized = req_sync_q;
  assign bus.icache_response_valid   = icache_rsp_q;
  assign bus.dcache_response_valid   = dcache_rsp_q;
  assign bus.response_idx            = rsp_idx_q;
  assign bus.response_status         = rsp_status_q;
  assign bus.response_data           = rsp_data_q;
`ifdef L2_REQUEST_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_stall_q, stat_stall_d;
  always_comb begin
    stat_issued_d = stat_issued_q + 32'(handshake);
    stat_stall_d  = stat_stall_q + 32'((bus.icache_dequeue_ready || bus.dcache_dequeue_ready) && !credit_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end
  assign stat_requests_issued     = stat_issued_q;
  assign stat_credit_stall_cycles = stat_stall_q;
`endif
endmodule

// File: tb/tb_l2_request_interface.sv
// tb_l2_request_interface: random + directed stimulus against a queue-based model with a decoupled scoreboard monitor.
module tb_l2_request_interface;
  localparam int IW = 2, LB = 512, MAXO = 2;
  typedef struct packed { logic [31:0] addr; logic unit; logic [IW-1:0] idx; logic sync; } req_t;
  typedef struct packed { logic unit; logic [IW-1:0] idx; logic status; logic [LB-1:0] data; } rsp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  l2_request_interface_if #(.IDX_WIDTH(IW), .LINE_BITS(LB)) bus ();
`ifdef L2_REQUEST_STATS_EN
  logic [31:0] s_req, s_stall;
  l2_request_interface #(.IDX_WIDTH(IW), .LINE_BITS(LB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stat_requests_issued(s_req), .stat_credit_stall_cycles(s_stall));
`else
  l2_request_interface #(.IDX_WIDTH(IW), .LINE_BITS(LB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif
  req_t slot_m[$], pend_m[$], exp_req[$];
  rsp_t exp_rsp[$];
  rsp_t last_rsp;
  bit prefer_d, run;
  bit fx_en, fx_st;
  logic [31:0] fx_addr;
  logic [IW-1:0] fx_idx;
  logic [LB-1:0] fx_data;
  int n_cmp, n_bad;
  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive_idle();
    bus.icache_dequeue_ready = 0; bus.icache_dequeue_addr = '0; bus.icache_dequeue_idx = '0;
    bus.dcache_dequeue_ready = 0; bus.dcache_dequeue_addr = '0; bus.dcache_dequeue_idx = '0;
    bus.dcache_dequeue_synchronized = 0; bus.l2_request_ready = 0;
    bus.l2_response_valid = 0; bus.l2_response_unit = 0; bus.l2_response_idx = '0;
    bus.l2_response_status = 0; bus.l2_response_data = '0;
  endtask
  // one clock of stimulus; the model decides acks from the queues and the arbitration rules
  task automatic cycle(input bit ir, input bit dr, input bit lr, input bit rs);
    bit can, gi, gd, hs;
    int k;
    req_t r;
    rsp_t p;
    logic [LB-1:0] rd;
    @(negedge clk);
    for (int j = 0; j < LB / 32; j++) rd[j*32 +: 32] = $urandom;
    bus.icache_dequeue_addr = fx_en ? fx_addr : $urandom;
    bus.icache_dequeue_idx = fx_en ? fx_idx : IW'($urandom);
    bus.dcache_dequeue_addr = fx_en ? fx_addr : $urandom;
    bus.dcache_dequeue_idx = fx_en ? fx_idx : IW'($urandom);
    bus.dcache_dequeue_synchronized = 1'($urandom);
    bus.icache_dequeue_ready = ir;
    bus.dcache_dequeue_ready = dr;
    bus.l2_request_ready = lr;
    can = (slot_m.size() == 0 || lr) && (pend_m.size() + slot_m.size() < MAXO);
    gi = can && ir && (!dr || !prefer_d);
    gd = can && dr && (!ir || prefer_d);
    hs = slot_m.size() != 0 && lr;
    rs = rs && pend_m.size() != 0;
    k = 0;
    if (rs) begin
      k = $urandom_range(pend_m.size() - 1);
      p = '{pend_m[k].unit, pend_m[k].idx, fx_en ? fx_st : 1'($urandom), fx_en ? fx_data : rd};
    end else p = '{1'($urandom), IW'($urandom), 1'($urandom), rd};
    bus.l2_response_valid = rs;
    bus.l2_response_unit = p.unit;
    bus.l2_response_idx = p.idx;
    bus.l2_response_status = p.status;
    bus.l2_response_data = p.data;
    #1;
    chk("icache_ack", LB'(bus.icache_dequeue_ack), LB'(gi));
    chk("dcache_ack", LB'(bus.dcache_dequeue_ack), LB'(gd));
    chk("req_valid", LB'(bus.l2_request_valid), LB'(slot_m.size() != 0));
    if (rs) begin
      exp_rsp.push_back(p);
      pend_m.delete(k);
    end
    if (hs) pend_m.push_back(slot_m.pop_front());
    if (gi || gd) begin
      r = gi ? '{bus.icache_dequeue_addr, 1'b0, bus.icache_dequeue_idx, 1'b0}
             : '{bus.dcache_dequeue_addr, 1'b1, bus.dcache_dequeue_idx, bus.dcache_dequeue_synchronized};
      slot_m.push_back(r);
      exp_req.push_back(r);
    end
    if (can && ir && dr) prefer_d = !prefer_d;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    drive_idle();
    slot_m.delete(); pend_m.delete(); exp_req.delete(); exp_rsp.delete();
    prefer_d = 0;
    last_rsp = '0;
    @(negedge clk);
    #1;
    chk("rst_icache_ack", LB'(bus.icache_dequeue_ack), '0);
    chk("rst_dcache_ack", LB'(bus.dcache_dequeue_ack), '0);
    chk("rst_req_valid", LB'(bus.l2_request_valid), '0);
    chk("rst_req_addr", LB'(bus.l2_request_addr), '0);
    chk("rst_req_unit", LB'(bus.l2_request_unit), '0);
    chk("rst_req_idx", LB'(bus.l2_request_idx), '0);
    chk("rst_req_sync", LB'(bus.l2_request_synchronized), '0);
    chk("rst_icache_rsp", LB'(bus.icache_response_valid), '0);
    chk("rst_dcache_rsp", LB'(bus.dcache_response_valid), '0);
    chk("rst_rsp_idx", LB'(bus.response_idx), '0);
    chk("rst_rsp_status", LB'(bus.response_status), '0);
    chk("rst_rsp_data", bus.response_data, '0);
    reset = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && (slot_m.size() != 0 || pend_m.size() != 0); i++) cycle(0, 0, 1, 1);
    repeat (2) cycle(0, 0, 1, 0);
  endtask
  // scoreboard monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    #2;
    if (run && !reset) begin
      if (bus.l2_request_valid) begin
        if (exp_req.size() == 0) chk("req_unexpected", LB'(1), '0);
        else begin
          chk("req_addr", LB'(bus.l2_request_addr), LB'(exp_req[0].addr));
          chk("req_unit", LB'(bus.l2_request_unit), LB'(exp_req[0].unit));
          chk("req_idx", LB'(bus.l2_request_idx), LB'(exp_req[0].idx));
          chk("req_sync", LB'(bus.l2_request_synchronized), LB'(exp_req[0].sync));
          if (bus.l2_request_ready) void'(exp_req.pop_front());
        end
      end
      if (bus.icache_response_valid || bus.dcache_response_valid) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", LB'(1), '0);
        else begin
          last_rsp = exp_rsp.pop_front();
          chk("rsp_strobe", LB'({bus.icache_response_valid, bus.dcache_response_valid}),
              LB'({!last_rsp.unit, last_rsp.unit}));
        end
      end
      chk("rsp_idx", LB'(bus.response_idx), LB'(last_rsp.idx));
      chk("rsp_status", LB'(bus.response_status), LB'(last_rsp.status));
      chk("rsp_data", bus.response_data, last_rsp.data);
      chk("rsp_latency", LB'(exp_rsp.size() > 1), '0);
    end
  end
  initial begin
    drive_idle();
    run = 1;
    do_reset();
    fx_en = 1; fx_addr = 32'h1000; fx_idx = 2; fx_st = 0; fx_data = '0;
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    fx_en = 0;
    drain();
    repeat (16) cycle(1, 1, 1, 1);
    drain();
    repeat (6) cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 1);
    repeat (3) cycle(1, 1, 1, 0);
    drain();
    cycle(1, 0, 1, 0);
    repeat (5) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    drain();
    fx_en = 1; fx_addr = 32'h2040; fx_idx = 3; fx_st = 1; fx_data = {64{8'hA5}};
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    fx_en = 0;
    drain();
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    drain();
    repeat (300) cycle(1'($urandom), 1'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0);
    do_reset();
    repeat (300) cycle(1'($urandom), 1'($urandom), ($urandom % 4) != 0, ($urandom % 2) == 0);
    drain();
    chk("end_req_queue", LB'(exp_req.size()), '0);
    chk("end_rsp_queue", LB'(exp_rsp.size()), '0);
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
